// File: rtl/instruction_fetch_unit_pkg.sv
// Shared RV32 pipeline definitions used by the fetch stage, its IF/ID
// register and the decode stage.
//   XLEN          : datapath width
//   NOP_INSTR     : bubble encoding (addi x0,x0,0)
//   fetch_state_e : fetch FSM states
//   if_id_t       : IF/ID pipeline bundle
package rv32_pipeline_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HELD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bundle: redirect/stall controls, instruction memory handshake
// and the IF/ID outputs.
//   master : the fetch unit (drives IMEM_ADDR/IMEM_READ and IF/ID outputs)
//   slave  : environment (branch unit, hazard unit, memory, decode stage)
interface instruction_fetch_unit_if;
  import rv32_pipeline_pkg::*;

  logic            BRANCH_SELECT;
  logic [XLEN-1:0] TARGET_ADDRESS;
  logic            STALL;
  logic            IMEM_BUSY;
  logic [XLEN-1:0] IMEM_INSTR;
  logic [XLEN-1:0] IMEM_ADDR;
  logic            IMEM_READ;
  logic [XLEN-1:0] PC_ID;
  logic [XLEN-1:0] PC_PLUS4_ID;
  logic [XLEN-1:0] INSTR_ID;
  logic            VALID_ID;

  modport master (
    input  BRANCH_SELECT, TARGET_ADDRESS, STALL, IMEM_BUSY, IMEM_INSTR,
    output IMEM_ADDR, IMEM_READ, PC_ID, PC_PLUS4_ID, INSTR_ID, VALID_ID
  );

  modport slave (
    output BRANCH_SELECT, TARGET_ADDRESS, STALL, IMEM_BUSY, IMEM_INSTR,
    input  IMEM_ADDR, IMEM_READ, PC_ID, PC_PLUS4_ID, INSTR_ID, VALID_ID
  );

endinterface

// File: rtl/instruction_fetch_unit_if_id_register.sv
// IF/ID pipeline register with load, hold and flush.
//   clk, rst : clock, synchronous active-high reset
//   load     : capture d
//   flush    : turn the entry into a bubble (valid=0, instr=NOP); wins over load
//   d, q     : IF/ID bundle in/out
// With neither load nor flush the register holds.
module if_id_register #(
  parameter logic [31:0] NOP_INSTR = rv32_pipeline_pkg::NOP_INSTR
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic                      flush,
  input  rv32_pipeline_pkg::if_id_t d,
  output rv32_pipeline_pkg::if_id_t q
);
  import rv32_pipeline_pkg::*;

  if_id_t q_q;
  if_id_t q_d;

  always_comb begin
    q_d = q_q;
    if (flush) begin
      q_d.valid = 1'b0;
      q_d.instr = NOP_INSTR;
    end else if (load) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '{pc: '0, pc_plus4: '0, instr: NOP_INSTR, valid: 1'b0};
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// RV32IM instruction-fetch stage: PC, instruction memory requests, IF/ID load,
// branch redirect with wrong-path flush, stall hold buffer, busy-memory drain.
//   CLK, RESET : clock, synchronous active-high reset
//   ifu        : fetch bundle (controls in, memory handshake, IF/ID outputs)
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = rv32_pipeline_pkg::NOP_INSTR
) (
  input  logic                      CLK,
  input  logic                      RESET,
  instruction_fetch_unit_if.master  ifu
);
  import rv32_pipeline_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  if_id_t          hold_q, hold_d;   // hold_q.valid marks the buffer occupied

  logic            imem_read;
  logic            complete;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] target;
  logic            ifid_load;
  logic            ifid_flush;
  if_id_t          ifid_in;
  if_id_t          ifid_out;

  assign imem_read = ~RESET & (state_q != HELD);
  assign complete  = imem_read & ~ifu.IMEM_BUSY;
  assign pc_plus4  = pc_q + 32'd4;
  assign target    = ifu.TARGET_ADDRESS & ~32'h3;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    redirect_pc_d = redirect_pc_q;
    hold_d        = hold_q;
    ifid_load     = 1'b0;
    ifid_flush    = 1'b0;
    ifid_in       = '{pc: pc_q, pc_plus4: pc_plus4, instr: ifu.IMEM_INSTR, valid: 1'b1};

    if (ifu.BRANCH_SELECT) begin
      ifid_flush   = 1'b1;
      hold_d.valid = 1'b0;
      case (state_q)
        RUN: begin
          if (complete) begin
            pc_d = target;
          end else begin
            // PC stays on the outstanding address until memory finishes
            redirect_pc_d = target;
            state_d       = DRAIN;
          end
        end
        HELD: begin
          pc_d    = target;
          state_d = RUN;
        end
        DRAIN:   redirect_pc_d = target;
        default: state_d = RUN;
      endcase
    end else begin
      case (state_q)
        RUN: begin
          if (complete) begin
            pc_d = pc_plus4;
            if (ifu.STALL) begin
              hold_d  = '{pc: pc_q, pc_plus4: pc_plus4, instr: ifu.IMEM_INSTR, valid: 1'b1};
              state_d = HELD;
            end else begin
              ifid_load = 1'b1;
            end
          end else begin
            ifid_flush = ~ifu.STALL;
          end
        end
        HELD: begin
          if (!ifu.STALL) begin
            ifid_in      = hold_q;
            ifid_load    = 1'b1;
            hold_d.valid = 1'b0;
            state_d      = RUN;
          end
        end
        DRAIN: begin
          ifid_flush = ~ifu.STALL;
          if (complete) begin
            pc_d    = redirect_pc_q;
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      redirect_pc_q <= '0;
      hold_q        <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      redirect_pc_q <= redirect_pc_d;
      hold_q        <= hold_d;
    end
  end

  if_id_register #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk   (CLK),
    .rst   (RESET),
    .load  (ifid_load),
    .flush (ifid_flush),
    .d     (ifid_in),
    .q     (ifid_out)
  );

  assign ifu.IMEM_ADDR   = pc_q;
  assign ifu.IMEM_READ   = imem_read;
  assign ifu.PC_ID       = ifid_out.pc;
  assign ifu.PC_PLUS4_ID = ifid_out.pc_plus4;
  assign ifu.INSTR_ID    = ifid_out.instr;
  assign ifu.VALID_ID    = ifid_out.valid;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed vector table,
// hand-written corner sequences, then randomized traffic against a
// behavioural model of the fetch rules.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .ifu   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        br;
    logic [31:0] tgt;
    logic        stall;
    logic        busy;
    logic [31:0] instr;
    logic        chk_pre;
    logic [31:0] e_addr;
    logic        e_read;
    logic        e_valid;
    logic        chk_pc;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
    logic [31:0] e_instr;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] iw(input logic [31:0] a);
    return 32'h5A00_0000 ^ a;
  endfunction

  function automatic vec_t v(input logic rst, input logic br, input logic [31:0] tgt,
                             input logic stall, input logic busy, input logic [31:0] instr,
                             input logic chk_pre, input logic [31:0] e_addr, input logic e_read,
                             input logic e_valid, input logic chk_pc, input logic [31:0] e_pc,
                             input logic [31:0] e_pc4, input logic [31:0] e_instr);
    vec_t r;
    r.rst = rst; r.br = br; r.tgt = tgt; r.stall = stall; r.busy = busy; r.instr = instr;
    r.chk_pre = chk_pre; r.e_addr = e_addr; r.e_read = e_read; r.e_valid = e_valid;
    r.chk_pc = chk_pc; r.e_pc = e_pc; r.e_pc4 = e_pc4; r.e_instr = e_instr;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic br, input logic [31:0] tgt,
                       input logic stall, input logic busy, input logic [31:0] instr);
    @(negedge CLK);
    RESET              = rst;
    bus.BRANCH_SELECT  = br;
    bus.TARGET_ADDRESS = tgt;
    bus.STALL          = stall;
    bus.IMEM_BUSY      = busy;
    bus.IMEM_INSTR     = instr;
    #1;
  endtask

  task automatic run_vec(input vec_t t);
    drive(t.rst, t.br, t.tgt, t.stall, t.busy, t.instr);
    if (t.chk_pre) begin
      chk("imem_addr", bus.IMEM_ADDR, t.e_addr);
      chk("imem_read", {31'd0, bus.IMEM_READ}, {31'd0, t.e_read});
    end
    @(posedge CLK);
    #1;
    chk("valid_id", {31'd0, bus.VALID_ID}, {31'd0, t.e_valid});
    chk("instr_id", bus.INSTR_ID, t.e_instr);
    if (t.chk_pc) begin
      chk("pc_id", bus.PC_ID, t.e_pc);
      chk("pc_plus4_id", bus.PC_PLUS4_ID, t.e_pc4);
    end
  endtask

  // Behavioural model: where fetch stands and what IF/ID should show.
  logic [31:0] m_pc, m_redir, m_park_pc, m_park_instr;
  logic        m_parked, m_discard;
  logic        e_valid;
  logic [31:0] e_pc, e_pc4, e_instr;

  task automatic model_step(input logic rst, input logic br, input logic [31:0] tgt,
                            input logic stall, input logic busy, input logic [31:0] instr);
    logic        done;
    logic [31:0] dest;
    dest = {tgt[31:2], 2'b00};
    done = !m_parked && !busy;
    if (rst) begin
      m_pc = 32'h0; m_redir = 32'h0; m_parked = 1'b0; m_discard = 1'b0;
      e_valid = 1'b0; e_instr = NOP; e_pc = 32'h0; e_pc4 = 32'h0;
    end else if (br) begin
      e_valid = 1'b0; e_instr = NOP;
      if (m_discard) m_redir = dest;
      else if (m_parked || done) m_pc = dest;
      else begin m_redir = dest; m_discard = 1'b1; end
      m_parked = 1'b0;
    end else if (m_discard) begin
      if (!stall) begin e_valid = 1'b0; e_instr = NOP; end
      if (done) begin m_pc = m_redir; m_discard = 1'b0; end
    end else if (m_parked) begin
      if (!stall) begin
        e_valid = 1'b1; e_pc = m_park_pc; e_pc4 = m_park_pc + 32'd4; e_instr = m_park_instr;
        m_parked = 1'b0;
      end
    end else if (done) begin
      if (stall) begin
        m_parked = 1'b1; m_park_pc = m_pc; m_park_instr = instr;
      end else begin
        e_valid = 1'b1; e_pc = m_pc; e_pc4 = m_pc + 32'd4; e_instr = instr;
      end
      m_pc = m_pc + 32'd4;
    end else if (!stall) begin
      e_valid = 1'b0; e_instr = NOP;
    end
  endtask

  initial begin
    bus.BRANCH_SELECT  = 1'b0;
    bus.TARGET_ADDRESS = 32'h0;
    bus.STALL          = 1'b0;
    bus.IMEM_BUSY      = 1'b0;
    bus.IMEM_INSTR     = 32'h0;

    // Reset, sequential fetch, taken branch, busy bubble, unaligned target.
    tbl.push_back(v(1,0,0,0,0,0,          0,0,0,       0,1,0,0,NOP));
    tbl.push_back(v(1,0,0,0,0,0,          1,0,0,       0,1,0,0,NOP));
    tbl.push_back(v(1,0,0,0,0,0,          1,0,0,       0,1,0,0,NOP));
    tbl.push_back(v(0,0,0,0,0,iw(0),      1,0,1,       1,1,0,4,iw(0)));
    tbl.push_back(v(0,0,0,0,0,iw(4),      1,4,1,       1,1,4,8,iw(4)));
    tbl.push_back(v(0,0,0,0,0,iw(8),      1,8,1,       1,1,8,32'hC,iw(8)));
    tbl.push_back(v(0,1,32'h100,0,0,iw(32'hC), 1,32'hC,1, 0,0,0,0,NOP));
    tbl.push_back(v(0,0,0,0,0,iw(32'h100),1,32'h100,1, 1,1,32'h100,32'h104,iw(32'h100)));
    tbl.push_back(v(0,0,0,0,0,iw(32'h104),1,32'h104,1, 1,1,32'h104,32'h108,iw(32'h104)));
    tbl.push_back(v(0,0,0,0,1,32'hBAD0BAD0,1,32'h108,1, 0,0,0,0,NOP));
    tbl.push_back(v(0,0,0,0,0,iw(32'h108),1,32'h108,1, 1,1,32'h108,32'h10C,iw(32'h108)));
    tbl.push_back(v(0,1,32'h203,0,0,iw(32'h10C),1,32'h10C,1, 0,0,0,0,NOP));
    tbl.push_back(v(0,0,0,0,0,iw(32'h200),1,32'h200,1, 1,1,32'h200,32'h204,iw(32'h200)));
    foreach (tbl[i]) run_vec(tbl[i]);

    // Redirect while memory is busy at 0x20: address holds, data discarded.
    run_vec(v(0,1,32'h20,0,0,iw(32'h204),1,32'h204,1, 0,0,0,0,NOP));
    run_vec(v(0,1,32'h80,0,1,32'h0,      1,32'h20,1,  0,0,0,0,NOP));
    run_vec(v(0,0,0,0,1,32'h0,           1,32'h20,1,  0,0,0,0,NOP));
    run_vec(v(0,0,0,0,1,32'h0,           1,32'h20,1,  0,0,0,0,NOP));
    run_vec(v(0,0,0,0,0,32'hDEAD0020,    1,32'h20,1,  0,0,0,0,NOP));
    run_vec(v(0,0,0,0,0,iw(32'h80),      1,32'h80,1,  1,1,32'h80,32'h84,iw(32'h80)));

    // Stall for 4 cycles while 0x40 completes.
    run_vec(v(0,1,32'h3C,0,0,iw(32'h84), 1,32'h84,1,  0,0,0,0,NOP));
    run_vec(v(0,0,0,0,0,iw(32'h3C),      1,32'h3C,1,  1,1,32'h3C,32'h40,iw(32'h3C)));
    run_vec(v(0,0,0,1,0,iw(32'h40),      1,32'h40,1,  1,1,32'h3C,32'h40,iw(32'h3C)));
    for (int k = 0; k < 3; k++)
      run_vec(v(0,0,0,1,0,32'hBADBAD00,  1,32'h44,0,  1,1,32'h3C,32'h40,iw(32'h3C)));
    run_vec(v(0,0,0,0,0,32'hBADBAD00,    1,32'h44,0,  1,1,32'h40,32'h44,iw(32'h40)));
    run_vec(v(0,0,0,0,0,iw(32'h44),      1,32'h44,1,  1,1,32'h44,32'h48,iw(32'h44)));

    // Branch + stall while HELD, target at the top of memory (PC+4 wraps).
    run_vec(v(0,0,0,1,0,iw(32'h48),      1,32'h48,1,  1,1,32'h44,32'h48,iw(32'h44)));
    run_vec(v(0,1,32'hFFFF_FFFC,1,0,32'hBADBAD01, 1,32'h4C,0, 0,0,0,0,NOP));
    run_vec(v(0,0,0,0,0,iw(32'hFFFF_FFFC),1,32'hFFFF_FFFC,1, 1,1,32'hFFFF_FFFC,32'h0,iw(32'hFFFF_FFFC)));
    run_vec(v(0,0,0,0,0,iw(32'h0),       1,32'h0,1,   1,1,32'h0,32'h4,iw(32'h0)));

    // Reset mid-operation while memory would complete.
    run_vec(v(0,0,0,0,1,32'h0,           1,32'h4,1,   0,0,0,0,NOP));
    run_vec(v(1,0,0,0,0,32'hBADBAD02,    1,32'h4,0,   0,1,0,0,NOP));
    run_vec(v(0,0,0,0,0,iw(32'h0),       1,32'h0,1,   1,1,32'h0,32'h4,iw(32'h0)));

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic        r_rst, r_br, r_stall, r_busy;
      logic [31:0] r_tgt, r_instr;
      r_rst   = (i < 2) || ($urandom_range(0, 99) == 0);
      r_br    = ($urandom_range(0, 99) < 15);
      r_stall = ($urandom_range(0, 99) < 25);
      r_busy  = ($urandom_range(0, 99) < 30);
      r_tgt   = $urandom;
      r_instr = $urandom;
      drive(r_rst, r_br, r_tgt, r_stall, r_busy, r_instr);
      if (i > 0) chk("rnd_imem_addr", bus.IMEM_ADDR, m_pc);
      chk("rnd_imem_read", {31'd0, bus.IMEM_READ}, {31'd0, (!r_rst && !m_parked)});
      model_step(r_rst, r_br, r_tgt, r_stall, r_busy, r_instr);
      @(posedge CLK);
      #1;
      chk("rnd_valid_id", {31'd0, bus.VALID_ID}, {31'd0, e_valid});
      chk("rnd_instr_id", bus.INSTR_ID, e_instr);
      if (e_valid) begin
        chk("rnd_pc_id", bus.PC_ID, e_pc);
        chk("rnd_pc_plus4_id", bus.PC_PLUS4_ID, e_pc4);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Instruction-fetch stage of the RV32IM pipeline. It holds the PC, issues word reads to instruction memory, and loads the IF/ID pipeline register. It consumes the redirect (`BRANCH_SELECT` / `TARGET_ADDRESS`) produced by the branch control unit in EX, flushing wrong-path instructions. It honours a hazard-unit `STALL` without losing an in-flight fetch, and tolerates a multi-cycle memory via a busy handshake.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded at reset.
- `NOP_INSTR`, default 32'h0000_0013: bubble encoding (`addi x0,x0,0`).

- `CLK` in 1: single clock, rising edge.
- `RESET` in 1: synchronous, active-high.
- `BRANCH_SELECT` in 1: redirect request from EX (jump or taken branch).
- `TARGET_ADDRESS` in 32: redirect target; bits [1:0] are ignored and treated as 00.
- `STALL` in 1: hazard unit, freezes PC advance and IF/ID.
- `IMEM_BUSY` in 1: memory not done. A fetch completes in a cycle with `IMEM_READ`=1 and `IMEM_BUSY`=0.
- `IMEM_INSTR` in 32: read data, valid in the completion cycle only.
- `IMEM_ADDR` out 32: fetch address, equal to PC (combinational).
- `IMEM_READ` out 1: read request (combinational).
- `PC_ID` out 32: IF/ID registered PC.
- `PC_PLUS4_ID` out 32: IF/ID registered PC+4.
- `INSTR_ID` out 32: IF/ID registered instruction.
- `VALID_ID` out 1: IF/ID holds a real instruction.

## Operation
- **States**
  - RUN: fetching.
  - HELD: one completed instruction parked in the hold buffer while stalled.
  - DRAIN: an outstanding fetch is being discarded after a redirect.
- **Priority:** `RESET` > `BRANCH_SELECT` > `STALL` > normal.
- **`IMEM_READ`:** 1 in RUN and DRAIN, 0 in HELD, 0 while `RESET`=1.
- **RUN**
  - Completion, no stall, no branch: IF/ID ← {PC, PC+4, `IMEM_INSTR`, 1}; PC ← PC+4.
  - Completion while `STALL`=1: hold buffer ← {PC, PC+4, `IMEM_INSTR`}; PC ← PC+4; IF/ID held; → HELD.
  - No completion: PC held. IF/ID ← bubble if `STALL`=0, held if `STALL`=1.
- **HELD**
  - `STALL`=1: everything held.
  - `STALL`=0: IF/ID ← buffer with `VALID_ID`=1; → RUN.
- **Branch** (`BRANCH_SELECT`=1, any `STALL` value)
  - IF/ID flushed: `VALID_ID`=0, `INSTR_ID`=`NOP_INSTR`.
  - Hold buffer invalidated.
  - From RUN with completion this cycle, or from HELD: the completing/buffered instruction is dropped; PC ← target; → RUN.
  - From RUN with `IMEM_BUSY`=1: REDIRECT_PC ← target; PC held, so the address stays stable; → DRAIN.
  - In DRAIN: REDIRECT_PC overwritten with the new target; stay DRAIN.
- **DRAIN**
  - On completion: data discarded; PC ← REDIRECT_PC; → RUN.
  - IF/ID ← bubble each cycle.
- **Arithmetic:** PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.

## Timing
- **Reset values:** PC=`RESET_PC`, state RUN, `PC_ID`=0, `PC_PLUS4_ID`=0, `INSTR_ID`=`NOP_INSTR`, `VALID_ID`=0, hold buffer invalid, REDIRECT_PC=0.
- **Reset mid-operation:** any state returns to the reset values at the next edge; outstanding memory data is ignored.
- **First fetch:** `IMEM_READ` asserts in the first cycle after `RESET` deasserts.
- **Zero-wait memory:** one instruction per cycle. IF/ID updates at the edge ending the completion cycle, so latency is 1 cycle from address to `INSTR_ID`.
- **Redirect penalty with zero-wait memory:** the target address appears on `IMEM_ADDR` the cycle after `BRANCH_SELECT`. The first target instruction reaches `VALID_ID`=1 two cycles after `BRANCH_SELECT`.
- **Stall:** IF/ID changes on no edge where `STALL`=1 and `BRANCH_SELECT`=0. Exiting HELD costs no extra cycle for the buffered instruction.
- **Registered signals:** all IF/ID outputs.

## Structure
- **Shared package `rv32_pipeline_pkg`:**
  - `NOP_INSTR` constant.
  - `XLEN`=32.
  - Fetch state enum (RUN, HELD, DRAIN).
  - IF/ID bundle fields: pc, pc_plus4, instr, valid.
- **Sub-module `if_id_register`:** IF/ID register with load, hold and flush inputs; reused by the ID stage. The FSM, PC and hold buffer stay in the top level.

## Test plan
- **Reset:** hold `RESET` 3 cycles, then release with `IMEM_BUSY`=0. Expect `VALID_ID`=0 and `INSTR_ID`=32'h13 during reset. `IMEM_ADDR`=0 and `IMEM_READ`=1 on release. Next edge gives `PC_ID`=0, `PC_PLUS4_ID`=4.
- **Sequential zero-wait:** feed words at 0, 4, 8. Expect `PC_ID` 0, 4, 8 on consecutive cycles, each with `VALID_ID`=1.
- **Taken branch:** `BRANCH_SELECT`=1, `TARGET_ADDRESS`=32'h100 while fetching 0xC. Expect `VALID_ID`=0 next cycle, `IMEM_ADDR`=32'h100, then `PC_ID`=32'h100 valid. 0xC is never valid.
- **Redirect during busy:** `IMEM_BUSY`=1 for 3 cycles at address 0x20; branch to 0x80 in the first busy cycle. `IMEM_ADDR` stays 0x20 until completion, the data is discarded, then `IMEM_ADDR`=0x80.
- **Stall with completion:** `STALL`=1 for 4 cycles while 0x40 completes. Expect IF/ID frozen and `IMEM_READ`=0 while HELD. After release, `PC_ID`=0x40 valid and `IMEM_ADDR`=0x44.
- **Branch + stall + wrap:** assert branch and stall together while HELD, with target 32'hFFFF_FFFC. Expect flush, then `PC_PLUS4_ID`=0 and the next fetch at address 0.
